// File: rtl/ide_host_pio.sv
// PIO-mode IDE/ATA host initiator: turns single register requests into timed CS/DA/DIOR-/DIOW- bus cycles.
// Define IDE_HOST_IORDY_EN to honour IORDY wait states with a bounded timeout.
module ide_host_pio #(
    parameter int T_SETUP       = 3,
    parameter int T_ACTIVE      = 8,
    parameter int T_RECOVER     = 6,
    parameter int IORDY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_cs3,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [2:0]  da,
    output logic        cs1fx_,
    output logic        cs3fx_,
    output logic        dior_,
    output logic        diow_,
    output logic [15:0] dd_out,
    output logic        dd_oe,
    input  logic [15:0] dd_in,
    input  logic        iordy_in,
    input  logic        intrq_in,
    output logic        irq
);

    // Counter reload values; a zero timing parameter behaves like one.
    localparam logic [7:0] SETUP_LOAD   = (T_SETUP < 1) ? 8'd0 : 8'(T_SETUP - 1);
    localparam logic [7:0] ACTIVE_LOAD  = (T_ACTIVE < 1) ? 8'd0 : 8'(T_ACTIVE - 1);
    localparam logic [7:0] RECOVER_LOAD = (T_RECOVER < 1) ? 8'd0 : 8'(T_RECOVER - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACTIVE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        err_r, err_s;
    logic        write_r, cs3_r;
    logic [2:0]  addr_r;
    logic [15:0] wdata_r;
    logic        intrq_meta_r;
    logic        accept_s, wait_s, timeout_s, bus_on_s;
    logic        sel_write_s, sel_cs3_s;
    logic [2:0]  sel_addr_s;
    logic [15:0] sel_wdata_s;
    logic        req_ready_s, busy_s, rsp_valid_s, rsp_err_s;
    logic        cs1fx_s, cs3fx_s, dior_s, diow_s, dd_oe_s;
    logic [2:0]  da_s;
    logic [15:0] dd_out_s, rsp_rdata_s;

    assign accept_s = req_valid && req_ready;

`ifdef IDE_HOST_IORDY_EN
    localparam logic [7:0] EXT_MAX = 8'(IORDY_TIMEOUT);
    logic       iordy_meta_r, iordy_sync_r;
    logic [7:0] ext_cnt_r;

    // IORDY synchroniser and count of wait states already inserted
    always_ff @(posedge clk) begin
        if (rst) begin
            iordy_meta_r <= 1'b0;
            iordy_sync_r <= 1'b0;
            ext_cnt_r    <= 8'd0;
        end else begin
            iordy_meta_r <= iordy_in;
            iordy_sync_r <= iordy_meta_r;
            if (state_r != ACTIVE) begin
                ext_cnt_r <= 8'd0;
            end else if ((cnt_r == 8'd0) && wait_s) begin
                ext_cnt_r <= ext_cnt_r + 8'd1;
            end else begin
                ext_cnt_r <= ext_cnt_r;
            end
        end
    end

    assign wait_s    = !iordy_sync_r && (ext_cnt_r != EXT_MAX);
    assign timeout_s = !iordy_sync_r && (ext_cnt_r == EXT_MAX);
`else
    // IORDY is deliberately ignored in this build.
    logic [8:0] unused_iordy_s;
    assign unused_iordy_s = {iordy_in, 8'(IORDY_TIMEOUT)};
    assign wait_s         = 1'b0;
    assign timeout_s      = 1'b0;
`endif

    // Phase state, phase counter and the request captured at handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            err_r   <= 1'b0;
            write_r <= 1'b0;
            cs3_r   <= 1'b0;
            addr_r  <= 3'd0;
            wdata_r <= 16'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            if (accept_s) begin
                write_r <= req_write;
                cs3_r   <= req_cs3;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end else begin
                write_r <= write_r;
                cs3_r   <= cs3_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    // Phase sequencing
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETUP;
                    cnt_s   = SETUP_LOAD;
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == 8'd0) begin
                    state_s = ACTIVE;
                    cnt_s   = ACTIVE_LOAD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ACTIVE: begin
                if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                end else if (wait_s) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = HOLD;
                    err_s   = timeout_s;
                end
            end
            HOLD: begin
                state_s = RECOVER;
                cnt_s   = RECOVER_LOAD;
            end
            RECOVER: begin
                if (cnt_r == 8'd0) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // While idle the incoming request decides the first SETUP cycle's bus values.
    assign sel_write_s = (state_r == IDLE) ? req_write : write_r;
    assign sel_cs3_s   = (state_r == IDLE) ? req_cs3 : cs3_r;
    assign sel_addr_s  = (state_r == IDLE) ? req_addr : addr_r;
    assign sel_wdata_s = (state_r == IDLE) ? req_wdata : wdata_r;

    // Output values for the phase entered on the coming edge
    always_comb begin
        bus_on_s    = (state_s == SETUP) || (state_s == ACTIVE) || (state_s == HOLD);
        req_ready_s = (state_s == IDLE);
        busy_s      = (state_s != IDLE);
        rsp_valid_s = (state_r == HOLD);
        rsp_err_s   = (state_r == HOLD) && err_r;
        cs1fx_s     = !(bus_on_s && !sel_cs3_s);
        cs3fx_s     = !(bus_on_s && sel_cs3_s);
        dior_s      = !((state_s == ACTIVE) && !sel_write_s);
        diow_s      = !((state_s == ACTIVE) && sel_write_s);
        dd_oe_s     = bus_on_s && sel_write_s;
        if (bus_on_s) begin
            da_s = sel_addr_s;
        end else begin
            da_s = da;
        end
        if (bus_on_s && sel_write_s) begin
            dd_out_s = sel_wdata_s;
        end else begin
            dd_out_s = dd_out;
        end
        if ((state_r == ACTIVE) && (state_s == HOLD) && !write_r) begin
            rsp_rdata_s = dd_in;
        end else begin
            rsp_rdata_s = rsp_rdata;
        end
    end

    // Output registers and interrupt synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 16'd0;
            da           <= 3'd0;
            cs1fx_       <= 1'b1;
            cs3fx_       <= 1'b1;
            dior_        <= 1'b1;
            diow_        <= 1'b1;
            dd_oe        <= 1'b0;
            dd_out       <= 16'd0;
            intrq_meta_r <= 1'b0;
            irq          <= 1'b0;
        end else begin
            req_ready    <= req_ready_s;
            busy         <= busy_s;
            rsp_valid    <= rsp_valid_s;
            rsp_err      <= rsp_err_s;
            rsp_rdata    <= rsp_rdata_s;
            da           <= da_s;
            cs1fx_       <= cs1fx_s;
            cs3fx_       <= cs3fx_s;
            dior_        <= dior_s;
            diow_        <= diow_s;
            dd_oe        <= dd_oe_s;
            dd_out       <= dd_out_s;
            intrq_meta_r <= intrq_in;
            irq          <= intrq_meta_r;
        end
    end

endmodule
